// File: rtl/mac_frame_fwd_if.sv
// Receive/transmit FIFO pair signals between the MAC and the frame forwarder.
// master = forwarder side, slave = MAC FIFO side.
interface mac_frame_fwd_if #(
  parameter int FREE_W = 12
);
  logic              rx_ptr_fifo_empty;
  logic              rx_ptr_fifo_rd;
  logic [15:0]       rx_ptr_fifo_dout;
  logic              rx_data_fifo_rd;
  logic [7:0]        rx_data_fifo_dout;
  logic              tx_data_fifo_wr;
  logic [7:0]        tx_data_fifo_din;
  logic [FREE_W-1:0] tx_data_fifo_free;
  logic              tx_ptr_fifo_wr;
  logic [15:0]       tx_ptr_fifo_din;
  logic              tx_ptr_fifo_full;

  modport master (
    input  rx_ptr_fifo_empty, rx_ptr_fifo_dout, rx_data_fifo_dout,
    input  tx_data_fifo_free, tx_ptr_fifo_full,
    output rx_ptr_fifo_rd, rx_data_fifo_rd, tx_data_fifo_wr, tx_data_fifo_din,
    output tx_ptr_fifo_wr, tx_ptr_fifo_din
  );

  modport slave (
    output rx_ptr_fifo_empty, rx_ptr_fifo_dout, rx_data_fifo_dout,
    output tx_data_fifo_free, tx_ptr_fifo_full,
    input  rx_ptr_fifo_rd, rx_data_fifo_rd, tx_data_fifo_wr, tx_data_fifo_din,
    input  tx_ptr_fifo_wr, tx_ptr_fifo_din
  );
endinterface

// File: rtl/mac_frame_fwd.sv
// MAC frame forwarder: pops rx frames, forwards good ones to the tx FIFOs, drops bad ones.
// Build option MAC_SWAP_EN: swap destination/source MAC addresses in forwarded headers.
module mac_frame_fwd #(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 14,
  parameter int FREE_W  = 12
) (
  input  logic            clk,
  input  logic            rst,
  mac_frame_fwd_if.master bus,
  output logic [15:0]     fwd_cnt,
  output logic [15:0]     drop_cnt
);
  localparam int HDR_LEN = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PTR    = 3'd1,
    CHECK  = 3'd2,
    HDR_LD = 3'd3,
    HDR_WR = 3'd4,
    BODY   = 3'd5,
    PTR_WR = 3'd6,
    DROP   = 3'd7
  } state_t;

  state_t            state_r;
  logic [11:0]       len_r;
  logic              err_r;
  logic [11:0]       rd_cnt_r;
  logic [3:0]        cap_cnt_r;
  logic [3:0]        wr_idx_r;
  logic [7:0]        hdr_r [HDR_LEN];
  logic              ptr_rd_r;
  logic              ptr_vld_r;
  logic              data_rd_r;
  logic              rd_vld_r;
  logic              tx_wr_r;
  logic              body_sel_r;
  logic [7:0]        hdr_din_r;
  logic              tx_ptr_wr_r;
  logic [15:0]       tx_ptr_din_r;
  logic [15:0]       fwd_cnt_r;
  logic [15:0]       drop_cnt_r;
  logic [FREE_W-1:0] free_s;
  logic [11:0]       body_len_s;
  logic              bad_s;
  logic              room_s;
  logic              unused_rsvd_s;

  // Buffer index emitted at header output position idx.
  function automatic logic [3:0] hdr_order(input logic [3:0] idx);
`ifdef MAC_SWAP_EN
    if (idx < 4'd6) begin
      hdr_order = idx + 4'd6;
    end else begin
      hdr_order = idx - 4'd6;
    end
`else
    hdr_order = idx;
`endif
  endfunction

  assign free_s        = bus.tx_data_fifo_free;
  assign unused_rsvd_s = ^bus.rx_ptr_fifo_dout[14:12];
  assign body_len_s    = len_r - 12'd12;
  assign bad_s  = err_r || (int'(len_r) < MIN_LEN) || (int'(len_r) > MAX_LEN);
  assign room_s = (int'(free_s) >= int'(len_r)) && !bus.tx_ptr_fifo_full;

  // Frame sequencer: pointer pop, length check, header capture/replay, body stream, drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      len_r        <= 12'd0;
      err_r        <= 1'b0;
      rd_cnt_r     <= 12'd0;
      cap_cnt_r    <= 4'd0;
      wr_idx_r     <= 4'd0;
      ptr_rd_r     <= 1'b0;
      ptr_vld_r    <= 1'b0;
      data_rd_r    <= 1'b0;
      rd_vld_r     <= 1'b0;
      tx_wr_r      <= 1'b0;
      body_sel_r   <= 1'b0;
      hdr_din_r    <= 8'd0;
      tx_ptr_wr_r  <= 1'b0;
      tx_ptr_din_r <= 16'd0;
      fwd_cnt_r    <= 16'd0;
      drop_cnt_r   <= 16'd0;
      for (int i = 0; i < HDR_LEN; i++) begin
        hdr_r[i] <= 8'd0;
      end
    end else begin
      // *_vld_r marks the cycle in which the matching FIFO dout is valid
      ptr_rd_r    <= 1'b0;
      ptr_vld_r   <= ptr_rd_r;
      rd_vld_r    <= data_rd_r;
      tx_ptr_wr_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!bus.rx_ptr_fifo_empty) begin
            ptr_rd_r <= 1'b1;
            state_r  <= PTR;
          end
        end
        PTR: begin
          if (ptr_vld_r) begin
            len_r   <= bus.rx_ptr_fifo_dout[11:0];
            err_r   <= bus.rx_ptr_fifo_dout[15];
            state_r <= CHECK;
          end
        end
        CHECK: begin
          if (bad_s) begin
            rd_cnt_r <= 12'd0;
            state_r  <= DROP;
          end else if (room_s) begin
            data_rd_r <= 1'b1;
            rd_cnt_r  <= 12'd1;
            cap_cnt_r <= 4'd0;
            state_r   <= HDR_LD;
          end
        end
        HDR_LD: begin
          if (rd_cnt_r < 12'd12) begin
            data_rd_r <= 1'b1;
            rd_cnt_r  <= rd_cnt_r + 12'd1;
          end else begin
            data_rd_r <= 1'b0;
          end
          if (rd_vld_r) begin
            hdr_r[cap_cnt_r] <= bus.rx_data_fifo_dout;
            cap_cnt_r        <= cap_cnt_r + 4'd1;
            // the first header byte out never depends on the byte captured this cycle
            if (cap_cnt_r == 4'd11) begin
              tx_wr_r   <= 1'b1;
              hdr_din_r <= hdr_r[hdr_order(4'd0)];
              wr_idx_r  <= 4'd1;
              state_r   <= HDR_WR;
            end
          end
        end
        HDR_WR: begin
          tx_wr_r   <= 1'b1;
          hdr_din_r <= hdr_r[hdr_order(wr_idx_r)];
          wr_idx_r  <= wr_idx_r + 4'd1;
          if (wr_idx_r == 4'd11) begin
            data_rd_r <= (body_len_s != 12'd0);
            rd_cnt_r  <= (body_len_s != 12'd0) ? 12'd1 : 12'd0;
            state_r   <= BODY;
          end
        end
        BODY: begin
          // body bytes pass straight from rx dout to tx din, one cycle behind their rd
          body_sel_r <= 1'b1;
          tx_wr_r    <= data_rd_r;
          if (rd_cnt_r < body_len_s) begin
            data_rd_r <= 1'b1;
            rd_cnt_r  <= rd_cnt_r + 12'd1;
          end else begin
            data_rd_r <= 1'b0;
          end
          if (!data_rd_r && (rd_cnt_r == body_len_s)) begin
            body_sel_r   <= 1'b0;
            tx_ptr_wr_r  <= 1'b1;
            tx_ptr_din_r <= {4'b0000, len_r};
            fwd_cnt_r    <= fwd_cnt_r + 16'd1;
            state_r      <= PTR_WR;
          end
        end
        PTR_WR: begin
          state_r <= IDLE;
        end
        DROP: begin
          if (rd_cnt_r < len_r) begin
            data_rd_r <= 1'b1;
            rd_cnt_r  <= rd_cnt_r + 12'd1;
          end else begin
            data_rd_r  <= 1'b0;
            drop_cnt_r <= drop_cnt_r + 16'd1;
            state_r    <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.rx_ptr_fifo_rd   = ptr_rd_r;
  assign bus.rx_data_fifo_rd  = data_rd_r;
  assign bus.tx_data_fifo_wr  = tx_wr_r;
  assign bus.tx_data_fifo_din = body_sel_r ? bus.rx_data_fifo_dout : hdr_din_r;
  assign bus.tx_ptr_fifo_wr   = tx_ptr_wr_r;
  assign bus.tx_ptr_fifo_din  = tx_ptr_din_r;
  assign fwd_cnt              = fwd_cnt_r;
  assign drop_cnt             = drop_cnt_r;
endmodule

// File: doc/mac_frame_fwd.md
Name: mac_frame_fwd

Overview:
- Consumer of the MAC receive FIFO pair and producer of the MAC transmit FIFO pair; turns the MAC into a frame loopback/forwarding port.
- Pops one receive pointer word per frame and reads the frame bytes from the receive data FIFO.
- Good frames are written to the transmit data FIFO, then one transmit pointer word is pushed. Bad frames are read out and discarded.
- Sits beside the MAC top level in the system clock domain.

Parameters:
- MAX_LEN, 1518, largest legal frame length in bytes.
- MIN_LEN, 14, smallest legal frame length in bytes.
- FREE_W, 12, width of the transmit data FIFO free-space count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rx_ptr_fifo_empty  in  1  receive pointer FIFO empty.
- rx_ptr_fifo_rd  out  1  receive pointer FIFO pop.
- rx_ptr_fifo_dout  in  16  pointer word: [15] error flag, [14:12] reserved, [11:0] byte length.
- rx_data_fifo_rd  out  1  receive data FIFO pop.
- rx_data_fifo_dout  in  8  receive data byte.
- tx_data_fifo_wr  out  1  transmit data FIFO push.
- tx_data_fifo_din  out  8  transmit data byte.
- tx_data_fifo_free  in  FREE_W  free bytes in transmit data FIFO.
- tx_ptr_fifo_wr  out  1  transmit pointer FIFO push.
- tx_ptr_fifo_din  out  16  transmit pointer word.
- tx_ptr_fifo_full  in  1  transmit pointer FIFO full.
- fwd_cnt  out  16  frames forwarded.
- drop_cnt  out  16  frames dropped.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- Reset mid-frame aborts immediately. FIFO contents are not repaired; system reset clears the FIFOs too.
- FIFO read model: rd asserted in cycle t gives dout valid in cycle t+1.
- IDLE: if rx_ptr_fifo_empty=0, pulse rx_ptr_fifo_rd for 1 cycle, then go to PTR.
- PTR: latch len=dout[11:0] and err=dout[15], then go to CHECK.
- CHECK: bad when err=1, len<MIN_LEN, or len>MAX_LEN.
  - Bad: go to DROP.
  - Good: stall in CHECK until tx_data_fifo_free>=len and tx_ptr_fifo_full=0, then go to HDR_LD.
- HDR_LD: read 12 bytes back-to-back (rd high for 12 cycles) into a 12-byte header buffer. No tx writes.
- HDR_WR: write 12 header bytes, 1 per cycle, in the order given by the optional feature.
- BODY:
  - Stream len-12 bytes; rd high for len-12 consecutive cycles.
  - Each byte is pushed with tx_data_fifo_wr exactly 1 cycle after its rd.
  - Throughput is 1 byte/clk.
  - The rd for the first body byte may overlap the last HDR_WR cycle.
- PTR_WR:
  - The cycle after the last data write, pulse tx_ptr_fifo_wr with din={4'b0,len}; the error flag is always 0.
  - Increment fwd_cnt, return to IDLE.
- DROP:
  - Read len bytes and discard them. If len>MAX_LEN (up to 4095), still read exactly len bytes so the FIFOs stay aligned.
  - len=0 reads nothing.
  - No tx activity. Increment drop_cnt, return to IDLE.
- Counters are 16-bit and wrap 0xFFFF->0.
- Byte counter is 12 bits. Bytes read always equal len.
- No back-to-back overlap between frames: after PTR_WR or DROP completes, there is at least 1 IDLE cycle before the next pointer pop.
- rx FIFOs never underflow within a frame; the MAC pushes the pointer only after all data.

Optional Feature:
- MAC_SWAP_EN defined: HDR_WR outputs buffer bytes 6..11 then 0..5, swapping destination and source addresses so replies return to the sender.
- MAC_SWAP_EN undefined: HDR_WR outputs bytes 0..11 in order; the frame is forwarded unmodified.
- Cycle timing is identical in both builds.

Test Plan:
- 64-byte good frame (ptr 0x0040, bytes 0x00..0x3F), free=4095 -> 64 tx writes. Then tx ptr 0x0040, fwd_cnt=1. With MAC_SWAP_EN, first 12 out = 06..0B,00..05; without it, 00..0B.
- Frame with ptr 0x8040 -> 64 rx reads, 0 tx writes, no tx ptr push, drop_cnt=1.
- Runt ptr 0x000A (10 bytes) -> 10 rx reads, dropped. Oversize ptr 0x0600 (1536) -> 1536 reads, dropped.
- Good 100-byte frame with free=50 -> stalls in CHECK with no rd. Raise free to 100 -> frame proceeds, tx ptr 0x0064.
- Three queued frames (60, 1518, 60 bytes) -> all forwarded in order, byte-exact, fwd_cnt=3. Body writes are contiguous at 1/clk.
- Assert rst during BODY of a 200-byte frame -> all outputs 0 next cycle, counters 0, state IDLE.
